// File: rtl/slc3_pkg.sv
// Shared types and constants for the SLC-3 datapath (v2).
package slc3_pkg;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_AND   = 2'b01,
    ALU_NOTA  = 2'b10,
    ALU_PASSA = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    PCM_INC   = 2'b00,
    PCM_BUS   = 2'b01,
    PCM_ADDER = 2'b10,
    PCM_HOLD  = 2'b11
  } pcmux_e;

  typedef enum logic [1:0] {
    A2_ZERO  = 2'b00,
    A2_OFF6  = 2'b01,
    A2_OFF9  = 2'b10,
    A2_OFF11 = 2'b11
  } addr2mux_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } mem_state_e;

  // Condition codes are packed {N,Z,P}
  localparam logic [2:0] CC_N   = 3'b100;
  localparam logic [2:0] CC_Z   = 3'b010;
  localparam logic [2:0] CC_P   = 3'b001;
  localparam logic [2:0] R7_IDX = 3'd7;

endpackage

// File: rtl/slc3_datapath_v2_if.sv
// Memory-side request/acknowledge bus of the SLC-3 datapath.
interface slc3_datapath_v2_if #(
  parameter int unsigned DATA_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/slc3_mem_if.sv
// Memory access engine: IDLE -> ACCESS -> DONE -> IDLE.
// Latches address/data/direction at start, holds mem_req until ack,
// and tells the datapath when and what to capture into MDR.
// Optional macro MEM_TIMEOUT_EN adds an ACCESS-cycle timeout with sticky error.
module slc3_mem_if
  import slc3_pkg::*;
#(
  parameter int unsigned DATA_W = 16
`ifdef MEM_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] mar_i,
  input  logic [DATA_W-1:0] mdr_i,
  slc3_datapath_v2_if.master mem,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              cap_en_o,
  output logic [DATA_W-1:0] cap_data_o
);

  mem_state_e        state_q;
  logic              req_q, we_q, busy_q, done_q;
  logic [DATA_W-1:0] addr_q, wdata_q;
  logic              timeout;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // Fires in the last permitted ACCESS cycle; an ack in that cycle still wins
  assign timeout = (state_q == ACCESS) && !mem.mem_ack &&
                   (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Count ACCESS cycles; sticky error on timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q != ACCESS) cnt_q <= '0;
      else if (!timeout)     cnt_q <= cnt_q + CNT_W'(1);
      if (timeout) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  // Engine FSM with registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            addr_q  <= mar_i;
            wdata_q <= mdr_i;
            we_q    <= we_i;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem.mem_ack || timeout) begin
            req_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  // A timed-out read returns all ones
  assign cap_en_o   = (state_q == ACCESS) && !we_q && (mem.mem_ack || timeout);
  assign cap_data_o = mem.mem_ack ? mem.mem_rdata : '1;

endmodule

// File: rtl/slc3_datapath_v2.sv
// SLC-3 datapath, second generation: bus, PC, IR, MAR, MDR, 8x register
// file, ALU, condition codes, BEN, bus-conflict detection and a
// request/acknowledge memory engine (slc3_mem_if).
// Optional macro MEM_TIMEOUT_EN enables the memory access timeout.
module slc3_datapath_v2
  import slc3_pkg::*;
#(
  parameter int unsigned       DATA_W   = 16,
  parameter logic [DATA_W-1:0] RESET_PC = '0
`ifdef MEM_TIMEOUT_EN
  , parameter int unsigned     TIMEOUT_CYC = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              LD_REG,
  input  logic              LD_BEN,
  input  logic              LD_CC,
  input  logic              LD_IR,
  input  logic              LD_PC,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              GateALU,
  input  logic              GatePC,
  input  logic              GateMARMUX,
  input  logic              GateMDR,
  input  logic              SR1MUX,
  input  logic              DRMUX,
  input  logic              ADDR1MUX,
  input  logic [1:0]        ADDR2MUX,
  input  logic [1:0]        ALUK,
  input  logic [1:0]        PCMUX,
  input  logic              MEM_START,
  input  logic              MEM_WE,
  slc3_datapath_v2_if.master mem,
  output logic [DATA_W-1:0] IR,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] MAR,
  output logic [DATA_W-1:0] MDR,
  output logic              BEN,
  output logic [2:0]        CC,
  output logic              MEM_BUSY,
  output logic              MEM_DONE,
  output logic              MEM_ERR,
  output logic              BUS_ERR
);

  logic [DATA_W-1:0] ir_q, pc_q, mar_q, mdr_q;
  logic [DATA_W-1:0] rf_q [8];
  logic [2:0]        cc_q, cc_d;
  logic              ben_q, bus_err_q;

  logic [DATA_W-1:0] bus, sr1, sr2, alu_b, alu_out;
  logic [DATA_W-1:0] addr1, addr2, adder, pc_d;
  logic [DATA_W-1:0] sext5, sext6, sext9, sext11;
  logic [2:0]        sr1_idx, dr_idx, gate_cnt;
  logic              cap_en;
  logic [DATA_W-1:0] cap_data;

  alu_op_e   alu_op;
  pcmux_e    pc_sel;
  addr2mux_e a2_sel;

  assign alu_op = alu_op_e'(ALUK);
  assign pc_sel = pcmux_e'(PCMUX);
  assign a2_sel = addr2mux_e'(ADDR2MUX);

  assign sext5  = {{(DATA_W-5){ir_q[4]}},   ir_q[4:0]};
  assign sext6  = {{(DATA_W-6){ir_q[5]}},   ir_q[5:0]};
  assign sext9  = {{(DATA_W-9){ir_q[8]}},   ir_q[8:0]};
  assign sext11 = {{(DATA_W-11){ir_q[10]}}, ir_q[10:0]};

  assign sr1_idx = SR1MUX ? ir_q[8:6] : ir_q[11:9];
  assign dr_idx  = DRMUX  ? R7_IDX    : ir_q[11:9];
  assign sr1     = rf_q[sr1_idx];
  assign sr2     = rf_q[ir_q[2:0]];
  assign alu_b   = ir_q[5] ? sext5 : sr2;

  // ALU
  always_comb begin
    alu_out = '0;
    unique case (alu_op)
      ALU_ADD:   alu_out = sr1 + alu_b;
      ALU_AND:   alu_out = sr1 & alu_b;
      ALU_NOTA:  alu_out = ~sr1;
      ALU_PASSA: alu_out = sr1;
    endcase
  end

  // Address adder operands
  always_comb begin
    addr2 = '0;
    unique case (a2_sel)
      A2_ZERO:  addr2 = '0;
      A2_OFF6:  addr2 = sext6;
      A2_OFF9:  addr2 = sext9;
      A2_OFF11: addr2 = sext11;
    endcase
  end

  assign addr1 = ADDR1MUX ? pc_q : sr1;
  assign adder = addr1 + addr2;

  assign gate_cnt = {2'b00, GateALU} + {2'b00, GatePC} +
                    {2'b00, GateMARMUX} + {2'b00, GateMDR};

  // Bus: a single enabled source drives it; none or a conflict yields zero
  always_comb begin
    bus = '0;
    if (gate_cnt == 3'd1) begin
      if (GateALU)         bus = alu_out;
      else if (GatePC)     bus = pc_q;
      else if (GateMARMUX) bus = adder;
      else                 bus = mdr_q;
    end
  end

  // Condition codes derived from the bus
  always_comb begin
    cc_d = CC_P;
    if (bus[DATA_W-1])  cc_d = CC_N;
    else if (bus == '0) cc_d = CC_Z;
  end

  // PC next value
  always_comb begin
    pc_d = pc_q;
    unique case (pc_sel)
      PCM_INC:   pc_d = pc_q + DATA_W'(1);
      PCM_BUS:   pc_d = bus;
      PCM_ADDER: pc_d = adder;
      PCM_HOLD:  pc_d = pc_q;
    endcase
  end

  // Register file write port
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 8; i++) rf_q[i] <= '0;
    end else if (LD_REG) begin
      rf_q[dr_idx] <= bus;
    end
  end

  // Architectural registers, CC, BEN and sticky bus-conflict flag
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      cc_q      <= CC_Z;
      ben_q     <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      if (LD_PC)  pc_q  <= pc_d;
      if (LD_IR)  ir_q  <= bus;
      if (LD_MAR) mar_q <= bus;
      // Memory read capture takes priority over a same-edge LD_MDR
      if (cap_en)      mdr_q <= cap_data;
      else if (LD_MDR) mdr_q <= bus;
      if (LD_CC)  cc_q  <= cc_d;
      if (LD_BEN) ben_q <= (ir_q[11] & cc_q[2]) | (ir_q[10] & cc_q[1]) |
                           (ir_q[9]  & cc_q[0]);
      if (gate_cnt > 3'd1) bus_err_q <= 1'b1;
    end
  end

  slc3_mem_if #(
    .DATA_W      (DATA_W)
`ifdef MEM_TIMEOUT_EN
    , .TIMEOUT_CYC (TIMEOUT_CYC)
`endif
  ) u_mem (
    .clk        (clk),
    .reset      (reset),
    .start_i    (MEM_START),
    .we_i       (MEM_WE),
    .mar_i      (mar_q),
    .mdr_i      (mdr_q),
    .mem        (mem),
    .busy_o     (MEM_BUSY),
    .done_o     (MEM_DONE),
    .err_o      (MEM_ERR),
    .cap_en_o   (cap_en),
    .cap_data_o (cap_data)
  );

  assign IR      = ir_q;
  assign PC      = pc_q;
  assign MAR     = mar_q;
  assign MDR     = mdr_q;
  assign BEN     = ben_q;
  assign CC      = cc_q;
  assign BUS_ERR = bus_err_q;

endmodule

// File: tb/tb_slc3_datapath_v2.sv
// Directed scoreboard bench for slc3_datapath_v2 (DATA_W=16, RESET_PC=0x3000).
module tb_slc3_datapath_v2;

  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic reset;
  logic LD_REG, LD_BEN, LD_CC, LD_IR, LD_PC, LD_MAR, LD_MDR;
  logic GateALU, GatePC, GateMARMUX, GateMDR;
  logic SR1MUX, DRMUX, ADDR1MUX;
  logic [1:0] ADDR2MUX, ALUK, PCMUX;
  logic MEM_START, MEM_WE;
  logic [DW-1:0] IR, PC, MAR, MDR;
  logic BEN;
  logic [2:0] CC;
  logic MEM_BUSY, MEM_DONE, MEM_ERR, BUS_ERR;

  slc3_datapath_v2_if #(.DATA_W(DW)) mif ();

  slc3_datapath_v2 #(.DATA_W(DW), .RESET_PC(16'h3000)) dut (
    .clk(clk), .reset(reset),
    .LD_REG(LD_REG), .LD_BEN(LD_BEN), .LD_CC(LD_CC), .LD_IR(LD_IR),
    .LD_PC(LD_PC), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
    .GateALU(GateALU), .GatePC(GatePC), .GateMARMUX(GateMARMUX), .GateMDR(GateMDR),
    .SR1MUX(SR1MUX), .DRMUX(DRMUX), .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX),
    .ALUK(ALUK), .PCMUX(PCMUX), .MEM_START(MEM_START), .MEM_WE(MEM_WE),
    .mem(mif),
    .IR(IR), .PC(PC), .MAR(MAR), .MDR(MDR), .BEN(BEN), .CC(CC),
    .MEM_BUSY(MEM_BUSY), .MEM_DONE(MEM_DONE), .MEM_ERR(MEM_ERR), .BUS_ERR(BUS_ERR)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  busy_cnt = 0;
  int  req_cnt  = 0;

  task automatic push(input string tag, input logic [31:0] exp);
    sb_q.push_back('{tag, exp});
  endtask

  task automatic pop_check(input logic [31:0] obs);
    sb_t e;
    checks++;
    assert (sb_q.size() != 0) else begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0h expected=entry", obs);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (MEM_BUSY) busy_cnt++;
  endtask

  task automatic clear_ctl();
    {LD_REG, LD_BEN, LD_CC, LD_IR, LD_PC, LD_MAR, LD_MDR} = '0;
    {GateALU, GatePC, GateMARMUX, GateMDR} = '0;
    {SR1MUX, DRMUX, ADDR1MUX} = '0;
    ADDR2MUX = 2'b00; ALUK = 2'b00; PCMUX = 2'b00;
    MEM_START = 1'b0; MEM_WE = 1'b0;
  endtask

  // Put a value into MDR through a zero-wait read
  task automatic load_mdr(input logic [DW-1:0] v);
    clear_ctl();
    MEM_START = 1'b1;
    step();
    MEM_START = 1'b0;
    mif.mem_ack = 1'b1; mif.mem_rdata = v;
    step();
    mif.mem_ack = 1'b0;
    step();
  endtask

  task automatic set_ir(input logic [DW-1:0] v);
    load_mdr(v);
    GateMDR = 1'b1; LD_IR = 1'b1;
    step();
    clear_ctl();
  endtask

  task automatic set_mar(input logic [DW-1:0] v);
    load_mdr(v);
    GateMDR = 1'b1; LD_MAR = 1'b1;
    step();
    clear_ctl();
  endtask

  initial begin
    clear_ctl();
    reset = 1'b1; mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    step(); step();
    reset = 1'b0;
    push("rst_pc", 32'h3000); push("rst_cc", 3'b010); push("rst_ben", 0);
    push("rst_mem_err", 0); push("rst_bus_err", 0); push("rst_mem_req", 0);
    push("rst_busy", 0); push("rst_done", 0); push("rst_ir", 0); push("rst_mdr", 0);
    pop_check(PC); pop_check(CC); pop_check(BEN); pop_check(MEM_ERR);
    pop_check(BUS_ERR); pop_check(mif.mem_req); pop_check(MEM_BUSY);
    pop_check(MEM_DONE); pop_check(IR); pop_check(MDR);

    // ADD R1, R1, #3 with R1 = 5
    set_ir(16'h1263);
    push("ir_load", 32'h1263); pop_check(IR);
    load_mdr(16'h0005);
    GateMDR = 1; LD_REG = 1; DRMUX = 0; step(); clear_ctl();
    SR1MUX = 1; GateALU = 1; LD_REG = 1; LD_CC = 1; ALUK = 2'b00;
    push("cc_add_pos", 3'b001); step(); clear_ctl(); pop_check(CC);
    SR1MUX = 1; GateALU = 1; ALUK = 2'b11; LD_MAR = 1;
    push("r1_after_add", 32'h0008); step(); clear_ctl(); pop_check(MAR);
    SR1MUX = 1; GateALU = 1; ALUK = 2'b10; LD_MAR = 1; LD_CC = 1;
    push("not_r1", 32'hFFF7); push("cc_neg", 3'b100); step(); clear_ctl();
    pop_check(MAR); pop_check(CC);
    SR1MUX = 1; GateALU = 1; ALUK = 2'b01; LD_MAR = 1; LD_CC = 1;
    push("and_imm", 32'h0000); push("cc_zero", 3'b010); step(); clear_ctl();
    pop_check(MAR); pop_check(CC);

    // Register-operand add with wrap, result into R7 via DRMUX
    load_mdr(16'hFFFF);
    GateMDR = 1; LD_REG = 1; DRMUX = 0; step(); clear_ctl();
    set_ir(16'h1241);
    SR1MUX = 1; GateALU = 1; ALUK = 2'b00; LD_MAR = 1; LD_REG = 1; DRMUX = 1;
    push("add_reg_wrap", 32'hFFFE); step(); clear_ctl(); pop_check(MAR);
    set_ir(16'h01C0);
    SR1MUX = 1; GateALU = 1; ALUK = 2'b11; LD_MAR = 1; LD_CC = 1;
    push("r7_read", 32'hFFFE); push("cc_neg2", 3'b100); step(); clear_ctl();
    pop_check(MAR); pop_check(CC);

    // BEN
    set_ir(16'h0800);
    LD_BEN = 1; push("ben_n_hit", 1); step(); clear_ctl(); pop_check(BEN);
    set_ir(16'h0400);
    LD_BEN = 1; push("ben_z_miss", 0); step(); clear_ctl(); pop_check(BEN);
    set_ir(16'h0800);
    LD_BEN = 1; LD_CC = 1; push("ben_old_cc", 1); push("cc_idle_bus", 3'b010);
    step(); clear_ctl(); pop_check(BEN); pop_check(CC);
    LD_BEN = 1; push("ben_new_cc", 0); step(); clear_ctl(); pop_check(BEN);

    // PC and address adder
    LD_PC = 1; PCMUX = 2'b00; push("pc_inc", 32'h3001); step(); clear_ctl(); pop_check(PC);
    set_ir(16'h01FF);
    GateMARMUX = 1; ADDR1MUX = 1; ADDR2MUX = 2'b10; LD_MAR = 1; LD_PC = 1; PCMUX = 2'b10;
    push("marmux_off9", 32'h3000); push("pc_adder", 32'h3000); step(); clear_ctl();
    pop_check(MAR); pop_check(PC);
    GateMARMUX = 1; ADDR1MUX = 0; ADDR2MUX = 2'b11; LD_MAR = 1;
    push("marmux_off11", 32'h01FF); step(); clear_ctl(); pop_check(MAR);
    GateMARMUX = 1; ADDR1MUX = 0; ADDR2MUX = 2'b01; LD_MAR = 1;
    push("marmux_off6", 32'hFFFF); step(); clear_ctl(); pop_check(MAR);
    load_mdr(16'hFFFF);
    GateMDR = 1; LD_PC = 1; PCMUX = 2'b01; push("pc_bus", 32'hFFFF); step(); clear_ctl();
    pop_check(PC);
    LD_PC = 1; PCMUX = 2'b00; push("pc_wrap", 32'h0000); step(); clear_ctl(); pop_check(PC);

    // Read with three wait states
    set_mar(16'h3000);
    busy_cnt = 0;
    MEM_START = 1; MEM_WE = 0;
    push("rd_req_a1", 1); push("rd_addr", 32'h3000); push("rd_we", 0);
    step(); clear_ctl();
    pop_check(mif.mem_req); pop_check(mif.mem_addr); pop_check(mif.mem_we);
    MEM_START = 1; MEM_WE = 1; GatePC = 1; LD_MAR = 1;
    push("rd_we_ign", 0); push("rd_addr_held", 32'h3000); push("rd_mar_upd", 32'h0000);
    push("rd_req_a2", 1);
    step(); clear_ctl();
    pop_check(mif.mem_we); pop_check(mif.mem_addr); pop_check(MAR); pop_check(mif.mem_req);
    step();
    step();
    mif.mem_ack = 1; mif.mem_rdata = 16'hBEEF; GatePC = 1; LD_MDR = 1;
    push("rd_mdr", 32'hBEEF); push("rd_done", 1); push("rd_req_off", 0);
    step(); clear_ctl(); mif.mem_ack = 0;
    pop_check(MDR); pop_check(MEM_DONE); pop_check(mif.mem_req);
    push("rd_done_1cyc", 0); push("rd_busy_cycles", 5);
    step();
    pop_check(MEM_DONE); pop_check(busy_cnt);
    mif.mem_ack = 1; mif.mem_rdata = 16'h1111;
    push("ack_idle_mdr", 32'hBEEF); push("ack_idle_done", 0);
    step(); mif.mem_ack = 0;
    pop_check(MDR); pop_check(MEM_DONE);

    // Write with zero wait states
    set_mar(16'h0042);
    load_mdr(16'h1234);
    MEM_START = 1; MEM_WE = 1;
    push("wr_we", 1); push("wr_addr", 32'h0042); push("wr_wdata", 32'h1234); push("wr_req", 1);
    step(); clear_ctl();
    pop_check(mif.mem_we); pop_check(mif.mem_addr); pop_check(mif.mem_wdata); pop_check(mif.mem_req);
    mif.mem_ack = 1; mif.mem_rdata = 16'hDEAD;
    push("wr_mdr_kept", 32'h1234); push("wr_done", 1);
    step(); mif.mem_ack = 0;
    pop_check(MDR); pop_check(MEM_DONE);
    step();

    // Bus conflict
    LD_PC = 1; PCMUX = 2'b00; step(); clear_ctl();
    GatePC = 1; GateALU = 1; LD_MAR = 1;
    push("conflict_bus", 32'h0000); push("bus_err_set", 1);
    step(); clear_ctl();
    pop_check(MAR); pop_check(BUS_ERR);
    step(); step();
    push("bus_err_sticky", 1); pop_check(BUS_ERR);

    // Read with no ack
    load_mdr(16'h5555);
    MEM_START = 1; MEM_WE = 0;
    step(); clear_ctl();
    req_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (mif.mem_req) req_cnt++;
      if (MEM_DONE) break;
      step();
    end
`ifdef MEM_TIMEOUT_EN
    push("to_req_cycles", 16); push("to_err", 1); push("to_mdr", 32'hFFFF); push("to_done", 1);
    pop_check(req_cnt); pop_check(MEM_ERR); pop_check(MDR); pop_check(MEM_DONE);
    step();
    MEM_START = 1; MEM_WE = 0;
    step(); clear_ctl();
`else
    push("noto_req_cycles", 100); push("noto_err", 0); push("noto_mdr", 32'h5555);
    push("noto_busy", 1);
    pop_check(req_cnt); pop_check(MEM_ERR); pop_check(MDR); pop_check(MEM_BUSY);
`endif

    // Reset in the middle of an access, with a coincident ack
    reset = 1; mif.mem_ack = 1; mif.mem_rdata = 16'hAAAA;
    push("rstmid_req", 0); push("rstmid_mdr", 0); push("rstmid_bus_err", 0);
    push("rstmid_mem_err", 0); push("rstmid_pc", 32'h3000); push("rstmid_busy", 0);
    step();
    reset = 0; mif.mem_ack = 0;
    pop_check(mif.mem_req); pop_check(MDR); pop_check(BUS_ERR);
    pop_check(MEM_ERR); pop_check(PC); pop_check(MEM_BUSY);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
